vector_dmem_responder: RTL
==========================

VECTOR_DMEM_RESPONDER -- requirements
Module: vector_dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words of backing storage.
REQ-002 SHALL have parameter LATENCY, default 2, number of wait cycles between request capture and response; legal range 1..15.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ren  input  1  read request from the address scheduler.
REQ-006 SHALL have port wen  input  1  write request from the address scheduler.
REQ-007 SHALL have port final_addr  input  32  byte address of the request.
REQ-008 SHALL have port final_storedata  input  32  write data, right-aligned (element in LSBs).
REQ-009 SHALL have port byte_ena  input  2  element width: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-010 SHALL have port dhit  output  1  one-cycle response strobe.
REQ-011 SHALL have port loaddata  output  32  read element, right-aligned and zero-extended.
REQ-012 SHALL have port fault  output  1  request rejected; qualified by dhit.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, WAIT, RESP.
REQ-015 In IDLE, at a rising edge with ren or wen high, SHALL capture ren, wen, final_addr, final_storedata, byte_ena, load wait counter with LATENCY-1 and go to WAIT.
REQ-016 Captured values SHALL be used for the whole transaction; input changes or request deassertion during WAIT/RESP SHALL be ignored.
REQ-017 In WAIT SHALL decrement the counter each cycle and go to RESP at the edge where the counter is 0; dhit therefore is high exactly in the cycle after edge E0+LATENCY, where E0 is the capture edge.
REQ-018 In RESP SHALL assert dhit for exactly one cycle and return to IDLE at the next edge; dhit SHALL be low in all other states.
REQ-019 A request held high in the cycle after RESP SHALL be captured as a new request (back-to-back minimum spacing LATENCY+2 cycles).
REQ-020 Fault SHALL be computed on captured values: ren and wen both high; byte_ena 11; halfword with addr[0]=1; word with addr[1:0]!=00; word index addr[31:2] >= DEPTH_WORDS.
REQ-021 On fault SHALL still complete the WAIT/RESP sequence, assert fault together with dhit, drive loaddata 0, and leave storage unmodified.
REQ-022 Valid write SHALL update only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all) at the IDLE/WAIT-to-RESP edge, using low bits of storedata shifted to those lanes.
REQ-023 Valid read SHALL drive loaddata during the RESP cycle with the addressed lanes shifted to bit 0, upper bits zero; loaddata SHALL be 0 outside RESP.
REQ-024 A read of an address written by the immediately preceding transaction SHALL return the new data.
REQ-025 fault SHALL be 0 outside RESP.

Reset
REQ-026 nRST low SHALL immediately force IDLE, counter 0, dhit 0, fault 0, loaddata 0, busy 0, independent of CLK.
REQ-027 nRST low SHALL clear all storage words to 0x00000000.
REQ-028 Reset asserted during WAIT or RESP SHALL abandon the transaction with no write committed and no dhit; first request after release SHALL be handled normally.

Verification
REQ-029 LATENCY=2: word write addr 0x10 data 0xDEADBEEF, then word read 0x10 -> dhit high in third cycle after each capture edge, loaddata 0xDEADBEEF, fault 0.
REQ-030 Byte write 0xAB to 0x13 over word 0x11223344 at 0x10 -> word read 0x10 returns 0xAB223344; byte read 0x13 returns 0x000000AB; half read 0x12 returns 0x0000AB22.
REQ-031 Half read addr 0x21, word write addr 0x22, byte_ena 11, ren=wen=1, word read addr 4*DEPTH_WORDS -> each gives dhit with fault 1, loaddata 0; subsequent read of 0x20 shows no change.
REQ-032 Capture write 0x40 then change final_addr/final_storedata and drop wen during WAIT -> exactly one dhit; only 0x40 updated with original data.
REQ-033 nRST pulsed low during WAIT of write to 0x50 -> dhit never asserts, busy 0 immediately, word read 0x50 after release returns 0x00000000.
REQ-034 ren held high continuously with LATENCY=1 -> dhit pulses every 3 cycles, busy low exactly one cycle between transactions.

Source files
------------

// File: rtl/vector_dmem_responder.sv
// vector_dmem_responder: fixed-latency data memory responder for a vector
// load/store unit. A request is captured in IDLE, held for LATENCY cycles
// in WAIT, and answered with a one-cycle dhit strobe in RESP. Misaligned,
// reserved-width, conflicting or out-of-range requests complete the same
// sequence but report fault and never touch storage.
module vector_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] final_addr,
    input  logic [31:0] final_storedata,
    input  logic [1:0]  byte_ena,
    output logic        dhit,
    output logic [31:0] loaddata,
    output logic        fault,
    output logic        busy
);

    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Byte lanes touched by an element of the given width at the given offset.
    function automatic logic [3:0] lane_mask(input logic [1:0] be, input logic [1:0] ofs);
        case (be)
            2'b00:   lane_mask = 4'b0001 << ofs;
            2'b01:   lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Widen a 4-bit lane mask into a 32-bit bit mask.
    function automatic logic [31:0] bit_mask(input logic [3:0] m);
        bit_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Replicate the right-aligned element across the word; the lane mask
    // then selects the copy that sits in the addressed lanes.
    function automatic logic [31:0] align_wdata(input logic [1:0] be, input logic [31:0] d);
        case (be)
            2'b00:   align_wdata = {4{d[7:0]}};
            2'b01:   align_wdata = {2{d[15:0]}};
            2'b10:   align_wdata = d;
            default: align_wdata = 32'h0000_0000;
        endcase
    endfunction

    // Shift the addressed element down to bit 0 and zero-extend.
    function automatic logic [31:0] extract_rdata(input logic [1:0] be, input logic [1:0] ofs,
                                                  input logic [31:0] w);
        case (be)
            2'b00:   extract_rdata = (w >> {ofs, 3'b000}) & 32'h0000_00FF;
            2'b01:   extract_rdata = (w >> {ofs[1], 4'b0000}) & 32'h0000_FFFF;
            2'b10:   extract_rdata = w;
            default: extract_rdata = 32'h0000_0000;
        endcase
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_next_s;
    logic              capture_s;
    logic              enter_resp_s;

    logic              ren_r;
    logic              wen_r;
    logic [31:0]       addr_r;
    logic [31:0]       data_r;
    logic [1:0]        be_r;

    logic              fault_s;
    logic              commit_wr_s;
    logic              valid_rd_s;
    logic [IDX_W-1:0]  word_idx_s;
    logic [31:0]       wmask_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rd_word_s;

    logic [31:0]       mem_r [0:DEPTH_WORDS-1];

    logic              dhit_r;
    logic              fault_r;
    logic [31:0]       loaddata_r;
    logic              busy_r;

    // State and wait counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic: capture in IDLE, count down in WAIT, single-cycle RESP.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        capture_s    = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ren || wen) begin
                    capture_s    = 1'b1;
                    cnt_next_s   = LAT_M1;
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    enter_resp_s = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    cnt_next_s   = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Request capture; later input activity is ignored until the next IDLE.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ren_r  <= 1'b0;
            wen_r  <= 1'b0;
            addr_r <= 32'h0000_0000;
            data_r <= 32'h0000_0000;
            be_r   <= 2'b00;
        end else if (capture_s) begin
            ren_r  <= ren;
            wen_r  <= wen;
            addr_r <= final_addr;
            data_r <= final_storedata;
            be_r   <= byte_ena;
        end
    end

    // Request legality, lane selection and read word, all from captured values.
    always_comb begin
        fault_s     = 1'b0;
        commit_wr_s = 1'b0;
        valid_rd_s  = 1'b0;
        word_idx_s  = addr_r[IDX_W+1:2];
        wmask_s     = bit_mask(lane_mask(be_r, addr_r[1:0]));
        wdata_s     = align_wdata(be_r, data_r);
        rd_word_s   = mem_r[word_idx_s];
        if ((ren_r && wen_r) || (be_r == 2'b11) ||
            ((be_r == 2'b01) && addr_r[0]) ||
            ((be_r == 2'b10) && (addr_r[1:0] != 2'b00)) ||
            (addr_r[31:2] >= DEPTH_LIM)) begin
            fault_s = 1'b1;
        end else begin
            fault_s = 1'b0;
        end
        commit_wr_s = enter_resp_s && wen_r && !fault_s;
        valid_rd_s  = ren_r && !fault_s;
    end

    // Backing storage: cleared by reset, byte-lane write on entry to RESP.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (commit_wr_s) begin
            mem_r[word_idx_s] <= (mem_r[word_idx_s] & ~wmask_s) | (wdata_s & wmask_s);
        end
    end

    // Registered response outputs, live only during the RESP cycle.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dhit_r     <= 1'b0;
            fault_r    <= 1'b0;
            loaddata_r <= 32'h0000_0000;
            busy_r     <= 1'b0;
        end else begin
            dhit_r     <= enter_resp_s;
            fault_r    <= enter_resp_s && fault_s;
            loaddata_r <= (enter_resp_s && valid_rd_s) ?
                          extract_rdata(be_r, addr_r[1:0], rd_word_s) : 32'h0000_0000;
            busy_r     <= (state_next_s != ST_IDLE);
        end
    end

    assign dhit     = dhit_r;
    assign fault    = fault_r;
    assign loaddata = loaddata_r;
    assign busy     = busy_r;

endmodule
